// File: rtl/enc_dec_pkg.sv
// ----------------------------------------------------------------------------
// enc_dec_pkg
// Shared definitions for the encoder/decoder control slice. It holds the APB
// register offsets, the operation mode and codeword width encodings, the
// operation FSM states, and the error code that marks a timed-out operation.
// ----------------------------------------------------------------------------
package enc_dec_pkg;

   // APB register offsets (low nibble of PADDR)
   localparam logic [3:0] CTRL_ADDR    = 4'h0;
   localparam logic [3:0] DATA_IN_ADDR = 4'h4;
   localparam logic [3:0] CW_ADDR      = 4'h8;
   localparam logic [3:0] NOISE_ADDR   = 4'hC;

   // CTRL[1:0] operation modes; 2'd3 is reserved and launches nothing
   localparam logic [1:0] MODE_ENC  = 2'd0;
   localparam logic [1:0] MODE_DEC  = 2'd1;
   localparam logic [1:0] MODE_FULL = 2'd2;

   // CODEWORD_WIDTH encodings; 2'd3 also selects the large codeword
   localparam logic [1:0] CW_SMALL  = 2'd0;
   localparam logic [1:0] CW_MEDIUM = 2'd1;
   localparam logic [1:0] CW_LARGE  = 2'd2;

   // num_of_errors value reported when the core never answers
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage : enc_dec_pkg

// File: rtl/op_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// op_ctrl_fsm
// Runs one core operation per start request: pulses core_start, waits for
// core_done (bounded by a timeout counter), captures the result and pulses
// operation_done.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_req       launch request (valid CTRL write while idle)
//   core_done       core result valid pulse
//   core_result     core output word
//   core_num_err    core error count
//   busy            high whenever an operation is in flight
//   core_start      one-cycle launch pulse to the core
//   data_out        captured result word (0 on timeout)
//   num_of_errors   captured error count (ERR_TIMEOUT on timeout)
//   operation_done  one-cycle completion pulse
// ----------------------------------------------------------------------------
module op_ctrl_fsm
   import enc_dec_pkg::*;
#(
   parameter int AMBA_WORD      = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_req,
   input  logic                 core_done,
   input  logic [AMBA_WORD-1:0] core_result,
   input  logic [1:0]           core_num_err,
   output logic                 busy,
   output logic                 core_start,
   output logic [AMBA_WORD-1:0] data_out,
   output logic [1:0]           num_of_errors,
   output logic                 operation_done
);

   // Counter value on the last permitted WAIT cycle
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] wait_cnt;
   logic       timeout_hit;

   assign timeout_hit = (wait_cnt == TO_LAST);
   assign busy        = (state != ST_IDLE);

   // NOTE: every signal driven here gets a default before the case, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_req) state_nxt = ST_START;
         ST_START: state_nxt = ST_WAIT;
         ST_WAIT:  if (core_done || timeout_hit) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         wait_cnt       <= '0;
         core_start     <= 1'b0;
         operation_done <= 1'b0;
         data_out       <= '0;
         num_of_errors  <= '0;
      end else begin
         state          <= state_nxt;
         // Pulses are registered from the state so the core sees clean,
         // glitch-free single-cycle strobes.
         core_start     <= (state == ST_START);
         operation_done <= (state == ST_DONE);

         if (state == ST_START)
            wait_cnt <= '0;
         else if (state == ST_WAIT)
            wait_cnt <= wait_cnt + 4'd1;

         // core_done only counts inside WAIT; results hold otherwise.
         if (state == ST_WAIT) begin
            if (core_done) begin
               data_out      <= core_result;
               num_of_errors <= core_num_err;
            end else if (timeout_hit) begin
               data_out      <= '0;
               num_of_errors <= ERR_TIMEOUT;
            end
         end
      end
   end

endmodule : op_ctrl_fsm

// File: rtl/apb_ctrl_regs.sv
// ----------------------------------------------------------------------------
// apb_ctrl_regs
// APB slave register bank in front of the encoder/decoder core. Holds CTRL,
// DATA_IN, CODEWORD_WIDTH and NOISE; a CTRL write of a valid mode launches one
// core operation through op_ctrl_fsm. Writes are dropped while busy so the
// core inputs stay stable for the whole operation.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE       APB control
//   PADDR, PWDATA             APB address / write data
//   PRDATA                    registered read data (loaded in setup phase)
//   PREADY                    always 1
//   core_data, core_noise     DATA_IN / NOISE registers to the core
//   core_mode                 CTRL[1:0]
//   Small/Medium/Large        one-hot codeword width decode
//   core_start                launch pulse
//   core_done, core_result,
//   core_num_err              core completion handshake and result
//   data_out, num_of_errors   captured result
//   operation_done            completion pulse
// ----------------------------------------------------------------------------
module apb_ctrl_regs
   import enc_dec_pkg::*;
#(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int TIMEOUT_CYCLES  = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic                       PREADY,
   output logic [AMBA_WORD-1:0]       core_data,
   output logic [AMBA_WORD-1:0]       core_noise,
   output logic [1:0]                 core_mode,
   output logic                       Small,
   output logic                       Medium,
   output logic                       Large,
   output logic                       core_start,
   input  logic                       core_done,
   input  logic [AMBA_WORD-1:0]       core_result,
   input  logic [1:0]                 core_num_err,
   output logic [AMBA_WORD-1:0]       data_out,
   output logic [1:0]                 num_of_errors,
   output logic                       operation_done
);

   logic [1:0]           ctrl_q;
   logic [AMBA_WORD-1:0] data_in_q;
   logic [1:0]           cw_q;
   logic [AMBA_WORD-1:0] noise_q;

   logic                 busy;
   logic                 wr_en;
   logic                 rd_setup;
   logic                 page_hit;
   logic                 sel_ctrl, sel_data, sel_cw, sel_noise;
   logic                 start_req;
   logic [AMBA_WORD-1:0] rd_data;

   // Registers live only in the lowest 16-byte page; anything above it
   // (e.g. 0x10) is an unmapped offset rather than an alias.
   assign page_hit  = (PADDR[AMBA_ADDR_WIDTH-1:4] == '0);
   assign sel_ctrl  = page_hit && (PADDR[3:0] == CTRL_ADDR);
   assign sel_data  = page_hit && (PADDR[3:0] == DATA_IN_ADDR);
   assign sel_cw    = page_hit && (PADDR[3:0] == CW_ADDR);
   assign sel_noise = page_hit && (PADDR[3:0] == NOISE_ADDR);

   assign wr_en     = PSEL && PENABLE && PWRITE && !busy;
   assign rd_setup  = PSEL && !PENABLE && !PWRITE;
   // The reserved mode 3 is stored but launches nothing.
   assign start_req = wr_en && sel_ctrl && (PWDATA[1:0] <= MODE_FULL);

   always_comb begin
      rd_data = '0;
      if (sel_ctrl)       rd_data[1:0] = ctrl_q;
      else if (sel_data)  rd_data      = data_in_q;
      else if (sel_cw)    rd_data[1:0] = cw_q;
      else if (sel_noise) rd_data      = noise_q;
   end

   // NOTE: reset is synchronous and clears every register, including PRDATA,
   // so the bus and core interfaces come up quiet.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= '0;
         data_in_q <= '0;
         cw_q      <= '0;
         noise_q   <= '0;
         PRDATA    <= '0;
      end else begin
         if (wr_en) begin
            if (sel_ctrl)  ctrl_q    <= PWDATA[1:0];
            if (sel_data)  data_in_q <= PWDATA;
            if (sel_cw)    cw_q      <= PWDATA[1:0];
            if (sel_noise) noise_q   <= PWDATA;
         end
         if (rd_setup)
            PRDATA <= rd_data;
      end
   end

   assign PREADY     = 1'b1;
   assign core_data  = data_in_q;
   assign core_noise = noise_q;
   assign core_mode  = ctrl_q;

   // Widths 2 and 3 both map to the large codeword, keeping the set one-hot.
   assign Small  = (cw_q == CW_SMALL);
   assign Medium = (cw_q == CW_MEDIUM);
   assign Large  = cw_q[1];

   op_ctrl_fsm #(
      .AMBA_WORD      (AMBA_WORD),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_op_ctrl_fsm (
      .clk            (clk),
      .rst            (rst),
      .start_req      (start_req),
      .core_done      (core_done),
      .core_result    (core_result),
      .core_num_err   (core_num_err),
      .busy           (busy),
      .core_start     (core_start),
      .data_out       (data_out),
      .num_of_errors  (num_of_errors),
      .operation_done (operation_done)
   );

endmodule : apb_ctrl_regs

// File: doc/apb_ctrl_regs.md
Name: apb_ctrl_regs

Overview:
APB slave register bank and operation controller sitting directly upstream of the Encoder/decoder core. It latches DATA_IN, CODEWORD_WIDTH, NOISE and CTRL from the APB bus. A CTRL write launches one operation: the block drives the core's data and one-hot Small/Medium/Large, waits for core_done, then captures the result and pulses operation_done.

Parameters:
AMBA_WORD, 32, APB data width and core word width
AMBA_ADDR_WIDTH, 20, APB address width
TIMEOUT_CYCLES, 15, maximum cycles in WAIT before forced completion (4-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write/not read
PADDR  in  AMBA_ADDR_WIDTH  APB byte address
PWDATA  in  AMBA_WORD  APB write data
PRDATA  out  AMBA_WORD  APB read data, registered
PREADY  out  1  tied 1 (zero wait states)
core_data  out  AMBA_WORD  DATA_IN register to core
core_noise  out  AMBA_WORD  NOISE register to core
core_mode  out  2  CTRL[1:0]: 0 encode, 1 decode, 2 full channel
Small  out  1  CODEWORD_WIDTH==0 (8-bit codeword)
Medium  out  1  CODEWORD_WIDTH==1 (16-bit codeword)
Large  out  1  CODEWORD_WIDTH==2 or 3 (32-bit codeword)
core_start  out  1  one-cycle launch pulse
core_done  in  1  core result valid, one-cycle pulse
core_result  in  AMBA_WORD  core output word
core_num_err  in  2  core error count (0/1/2)
data_out  out  AMBA_WORD  captured result
num_of_errors  out  2  captured error count; 3 = timeout
operation_done  out  1  one-cycle completion pulse

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous, active-high. Sampled on rising edge; all registers and outputs clear to 0, state IDLE. rst mid-operation aborts with no operation_done.
- Register map (PADDR[3:0]): 0x0 CTRL[1:0], 0x4 DATA_IN, 0x8 CODEWORD_WIDTH[1:0], 0xC NOISE. Other offsets: writes dropped, reads return 0. Unused bits are not stored and read as 0.
- Write: takes effect on the edge where PSEL&PENABLE&PWRITE. Read: PRDATA loads on the setup edge (PSEL&!PENABLE&!PWRITE) and is valid in the access phase. Otherwise PRDATA holds.
- Small/Medium/Large decode combinationally from the CODEWORD_WIDTH register and are always one-hot.
- FSM:
  - IDLE: a CTRL write with value 0..2 stores CTRL and moves to START. A CTRL write of 3 is stored but starts nothing.
  - START: core_start=1 for exactly one cycle; clear timeout counter; go to WAIT.
  - WAIT: on core_done, capture data_out<=core_result and num_of_errors<=core_num_err, then go to DONE. If the counter reaches TIMEOUT_CYCLES without core_done, set data_out<=0 and num_of_errors<=3, then go to DONE.
  - DONE: operation_done=1 for one cycle; go to IDLE.
- Latency: CTRL write edge -> core_start next cycle -> with core_done one cycle later, operation_done 2 cycles after core_done. Minimum 4 cycles from the CTRL write edge.
- Busy (state != IDLE): all APB writes are dropped, so the core inputs are stable for the whole operation. Reads still work.
- core_done outside WAIT is ignored. data_out and num_of_errors hold until the next capture.

Decomposition:
- Shared package enc_dec_pkg:
  - register offsets: CTRL_ADDR, DATA_IN_ADDR, CW_ADDR, NOISE_ADDR
  - mode encodings: MODE_ENC, MODE_DEC, MODE_FULL
  - width encodings: CW_SMALL, CW_MEDIUM, CW_LARGE
  - FSM state encodings, and the timeout code ERR_TIMEOUT=2'd3
- One natural sub-module: op_ctrl_fsm, covering the state register, timeout counter, start/done pulses and result capture. The APB register bank stays in the top.

Test Plan:
1. Write DATA_IN=0xA5A5A5A5, CW=1, NOISE=0x00000004, then read each back -> PRDATA 0xA5A5A5A5, 0x1, 0x4; Medium=1, Small=Large=0.
2. Write CTRL=0; core model returns core_done 1 cycle after core_start with core_result=0x12345678, core_num_err=1 -> single core_start pulse; operation_done 4 cycles after the CTRL write edge; data_out=0x12345678, num_of_errors=1.
3. While in WAIT, write DATA_IN=0xFFFFFFFF and CTRL=2 -> core_data stays 0xA5A5A5A5; no second core_start; DATA_IN reads back 0xA5A5A5A5.
4. Core never asserts core_done -> after 15 WAIT cycles operation_done pulses with data_out=0, num_of_errors=3.
5. Write CTRL=3, and write/read offset 0x10 -> no core_start; the 0x10 read returns 0x0. Then write CW=3 -> Large=1.
6. Assert rst in WAIT -> all outputs 0 on the next edge; no operation_done; a subsequent CTRL=1 write runs normally.
